// File: rtl/ase_hssi_pkt_monitor.sv
// ase_hssi_pkt_monitor
//   Passive tap on one HSSI AXI-Stream channel. Builds one summary record per
//   completed packet (id, beats, bytes, start cycle, error flags), buffers the
//   records in a small FIFO and presents them on a valid/ready port. The tapped
//   stream is only observed, never driven or stalled.
//
//   Ports:
//     clk, SoftReset_n         clock, asynchronous active-low reset
//     mon_t*                   tapped AXI-Stream signals (inputs only)
//     rec_valid / rec_ready    record handshake; rec_* show the FIFO head
//     drop_cnt                 records lost to a full FIFO (saturating)
//     proto_err_cnt            protocol violations (saturating)
//
//   Optional feature: define ASE_HSSI_MON_PROTOCOL_CHECK_EN to enable the
//   stall-stability / empty-tkeep checker. Without it proto_err_cnt is 0.
module ase_hssi_pkt_monitor #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                SoftReset_n,
    input  logic                mon_tvalid,
    input  logic                mon_tready,
    input  logic [DATA_W-1:0]   mon_tdata,
    input  logic [DATA_W/8-1:0] mon_tkeep,
    input  logic                mon_tlast,
    input  logic                mon_tuser,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [31:0]         rec_pkt_id,
    output logic [15:0]         rec_beats,
    output logic [15:0]         rec_bytes,
    output logic [31:0]         rec_start_cycle,
    output logic                rec_err,
    output logic                rec_trunc,
    output logic [15:0]         drop_cnt,
    output logic [15:0]         proto_err_cnt
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] pkt_id;
        logic [15:0] beats;
        logic [15:0] bytes;
        logic [31:0] start_cycle;
        logic        err;
        logic        trunc;
    } rec_t;

    typedef enum logic [1:0] {IDLE, IN_PKT, PUSH} state_t;

    state_t      state, state_n;
    logic [31:0] cyc_cnt;
    logic [31:0] pkt_id;
    logic [31:0] cur_start;
    logic [15:0] cur_beats, cur_bytes, keep_cnt;
    logic [16:0] bytes_sum;
    logic        cur_err, cur_trunc, pend_err;
    logic        beat, first, push, viol;

    assign beat  = mon_tvalid & mon_tready;
    // A beat outside IN_PKT always opens a new packet, including in PUSH.
    assign first = beat & (state != IN_PKT);
    assign push  = (state == PUSH);

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < KEEP_W; i++) keep_cnt = keep_cnt + 16'(mon_tkeep[i]);
    end
    assign bytes_sum = {1'b0, cur_bytes} + {1'b0, keep_cnt};

`ifdef ASE_HSSI_MON_PROTOCOL_CHECK_EN
    logic              stall_q, last_q, user_q;
    logic [DATA_W-1:0] data_q;
    logic [KEEP_W-1:0] keep_q;
    logic              viol_hold, viol_keep;
    logic [16:0]       proto_sum;

    // Once stalled, the beat must stay presented and unchanged.
    assign viol_hold = stall_q & (!mon_tvalid || mon_tdata != data_q || mon_tkeep != keep_q
                                  || mon_tlast != last_q || mon_tuser != user_q);
    assign viol_keep = beat & (mon_tkeep == '0);
    assign viol      = viol_hold | viol_keep;
    assign proto_sum = {1'b0, proto_err_cnt} + 17'(viol_hold) + 17'(viol_keep);

    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            stall_q       <= 1'b0;
            data_q        <= '0;
            keep_q        <= '0;
            last_q        <= 1'b0;
            user_q        <= 1'b0;
            proto_err_cnt <= '0;
        end else begin
            stall_q       <= mon_tvalid & !mon_tready;
            data_q        <= mon_tdata;
            keep_q        <= mon_tkeep;
            last_q        <= mon_tlast;
            user_q        <= mon_tuser;
            proto_err_cnt <= proto_sum[16] ? 16'hFFFF : proto_sum[15:0];
        end
    end
`else
    logic unused_tdata;
    assign unused_tdata  = ^mon_tdata;
    assign viol          = 1'b0;
    assign proto_err_cnt = '0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (beat) state_n = mon_tlast ? PUSH : IN_PKT;
            IN_PKT:  if (beat && mon_tlast) state_n = PUSH;
            PUSH:    state_n = beat ? (mon_tlast ? PUSH : IN_PKT) : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            pkt_id    <= '0;
            cur_start <= '0;
            cur_beats <= '0;
            cur_bytes <= '0;
            cur_err   <= 1'b0;
            cur_trunc <= 1'b0;
            pend_err  <= 1'b0;
        end else begin
            state   <= state_n;
            cyc_cnt <= cyc_cnt + 32'd1;
            if (push) pkt_id <= pkt_id + 32'd1;
            if (first) begin
                cur_start <= cyc_cnt;
                cur_beats <= 16'd1;
                cur_bytes <= keep_cnt;
                cur_err   <= mon_tuser | viol | pend_err;
                cur_trunc <= 1'b0;
                pend_err  <= 1'b0;
            end else if (beat) begin
                cur_beats <= (cur_beats == 16'hFFFF) ? 16'hFFFF : cur_beats + 16'd1;
                cur_bytes <= bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
                cur_err   <= cur_err | mon_tuser | viol;
                cur_trunc <= cur_trunc | (cur_beats == 16'hFFFF) | bytes_sum[16];
            end else if (viol) begin
                // A violation with no packet open is charged to the next packet.
                if (state == IN_PKT) cur_err <= 1'b1;
                else                 pend_err <= 1'b1;
            end
        end
    end

    // Record FIFO
    rec_t             mem [FIFO_DEPTH];
    rec_t             head, wr_rec;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, pop, push_ok;

    assign wr_rec  = '{pkt_id: pkt_id, beats: cur_beats, bytes: cur_bytes,
                       start_cycle: cur_start, err: cur_err, trunc: cur_trunc};
    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign pop     = rec_valid & rec_ready;
    assign push_ok = push & (!full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_rec;
    end

    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (push && !push_ok && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Fields read as zero while empty so nothing stale is exposed after reset.
    assign rec_valid       = (count != '0);
    assign head            = mem[rd_ptr];
    assign rec_pkt_id      = rec_valid ? head.pkt_id      : '0;
    assign rec_beats       = rec_valid ? head.beats       : '0;
    assign rec_bytes       = rec_valid ? head.bytes       : '0;
    assign rec_start_cycle = rec_valid ? head.start_cycle : '0;
    assign rec_err         = rec_valid & head.err;
    assign rec_trunc       = rec_valid & head.trunc;
endmodule
